commit_trace_buffer: RTL and testbench

//  Parametrised hardware trace of register-file writebacks for the MIPS cores (single-cycle and pipelined).

---
 rtl/commit_trace_buffer_if.sv | 29 ++
 rtl/commit_trace_buffer.sv | 111 +++++++++++
 tb/tb_commit_trace_buffer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_buffer_if.sv
// Writeback tap and readout stream for the commit trace buffer.
// The trace source/consumer side uses master; the buffer uses slave.
interface commit_trace_buffer_if #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int REG_W   = 5,
  parameter int STAMP_W = 16
);
  logic               wb_valid;
  logic [PC_W-1:0]    wb_pc;
  logic [REG_W-1:0]   wb_reg;
  logic [DATA_W-1:0]  wb_data;
  logic               rd_ready;
  logic               rd_valid;
  logic [STAMP_W-1:0] rd_stamp;
  logic [PC_W-1:0]    rd_pc;
  logic [REG_W-1:0]   rd_reg;
  logic [DATA_W-1:0]  rd_data;

  modport master (
    output wb_valid, wb_pc, wb_reg, wb_data, rd_ready,
    input  rd_valid, rd_stamp, rd_pc, rd_reg, rd_data
  );

  modport slave (
    input  wb_valid, wb_pc, wb_reg, wb_data, rd_ready,
    output rd_valid, rd_stamp, rd_pc, rd_reg, rd_data
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Circular trace of register-file writebacks with a first-word fall-through
// readout stream; MODE picks drop-new (0) or overwrite-oldest (1) when full.
module commit_trace_buffer #(
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int REG_W       = 5,
  parameter int STAMP_W     = 16,
  parameter int DEPTH       = 16,
  parameter int MODE        = 0,
  parameter int FILTER_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     ovf_clr,
  commit_trace_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [STAMP_W-1:0] memStamp [DEPTH];
  logic [PC_W-1:0]    memPc    [DEPTH];
  logic [REG_W-1:0]   memReg   [DEPTH];
  logic [DATA_W-1:0]  memData  [DEPTH];

  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STAMP_W-1:0] stamp_q;
  logic               overflow_q, overflow_d;

  logic cap, pop, isFull, isEmpty, doWrite, advRead, setOvf;

  assign isEmpty = (count_q == '0);
  assign isFull  = (count_q == CNT_W'(DEPTH));
  assign cap     = en & bus.wb_valid & ~((FILTER_ZERO != 0) && (bus.wb_reg == '0));
  assign pop     = ~isEmpty & bus.rd_ready;

  // When full, a capture needs either a pop to make room or MODE1's overwrite.
  always_comb begin
    doWrite    = 1'b0;
    advRead    = pop;
    setOvf     = 1'b0;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (cap) begin
      if (!isFull || pop) begin
        doWrite = 1'b1;
      end else if (MODE != 0) begin
        doWrite = 1'b1;
        advRead = 1'b1;
        setOvf  = 1'b1;
      end else begin
        setOvf  = 1'b1;
      end
    end

    if (doWrite) wrPtr_d = wrPtr_q + 1'b1;
    if (advRead) rdPtr_d = rdPtr_q + 1'b1;

    if (doWrite && !advRead)      count_d = count_q + 1'b1;
    else if (advRead && !doWrite) count_d = count_q - 1'b1;

    if (setOvf)       overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      stamp_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      stamp_q    <= stamp_q + 1'b1;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; entries are only meaningful between rdPtr and wrPtr.
  always_ff @(posedge clk) begin
    if (!rst && doWrite) begin
      memStamp[wrPtr_q] <= stamp_q;
      memPc[wrPtr_q]    <= bus.wb_pc;
      memReg[wrPtr_q]   <= bus.wb_reg;
      memData[wrPtr_q]  <= bus.wb_data;
    end
  end

  assign bus.rd_valid = ~isEmpty;
  assign bus.rd_stamp = memStamp[rdPtr_q];
  assign bus.rd_pc    = memPc[rdPtr_q];
  assign bus.rd_reg   = memReg[rdPtr_q];
  assign bus.rd_data  = memData[rdPtr_q];

  assign count    = count_q;
  assign full     = isFull;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Drives identical random and directed traffic into a MODE0 and a MODE1 buffer
// and compares both against queue-based reference models.
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;

  typedef struct {
    logic [15:0] stamp;
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst, en, ovfClr;
  logic [4:0] count0, count1;
  logic full0, full1, ovf0, ovf1;

  commit_trace_buffer_if if0 ();
  commit_trace_buffer_if if1 ();

  commit_trace_buffer #(.DEPTH(DEPTH), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .ovf_clr(ovfClr), .bus(if0.slave),
    .count(count0), .full(full0), .overflow(ovf0)
  );

  commit_trace_buffer #(.DEPTH(DEPTH), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .ovf_clr(ovfClr), .bus(if1.slave),
    .count(count1), .full(full1), .overflow(ovf1)
  );

  always #5 clk = ~clk;

  entry_t      q0[$];
  entry_t      q1[$];
  bit          mOvf [2];
  logic [15:0] mStamp [2];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: a plain queue, oldest at the front.
  task automatic modelStep(input int m, input logic r, e, v, input logic [31:0] pc,
                           input logic [4:0] rg, input logic [31:0] d, input logic rdy, clr);
    entry_t q[$];
    entry_t ent;
    bit     cap, pop, setOvf;
    if (m == 0) q = q0; else q = q1;
    if (r) begin
      q.delete();
      mOvf[m]   = 1'b0;
      mStamp[m] = '0;
    end else begin
      cap    = e && v && (rg != 5'd0);
      pop    = (q.size() != 0) && rdy;
      setOvf = 1'b0;
      ent.stamp = mStamp[m];
      ent.pc    = pc;
      ent.rg    = rg;
      ent.data  = d;
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) begin
          q.push_back(ent);
        end else begin
          setOvf = 1'b1;
          if (m == 1) begin
            void'(q.pop_front());
            q.push_back(ent);
          end
        end
      end
      if (setOvf)   mOvf[m] = 1'b1;
      else if (clr) mOvf[m] = 1'b0;
      mStamp[m] = mStamp[m] + 16'd1;
    end
    if (m == 0) q0 = q; else q1 = q;
  endtask

  task automatic checkDut(input int m);
    entry_t q[$];
    logic        valid, fl, ovf;
    logic [4:0]  cnt, rg;
    logic [15:0] st;
    logic [31:0] pc, data;
    if (m == 0) begin
      q = q0; valid = if0.rd_valid; cnt = count0; fl = full0; ovf = ovf0;
      st = if0.rd_stamp; pc = if0.rd_pc; rg = if0.rd_reg; data = if0.rd_data;
    end else begin
      q = q1; valid = if1.rd_valid; cnt = count1; fl = full1; ovf = ovf1;
      st = if1.rd_stamp; pc = if1.rd_pc; rg = if1.rd_reg; data = if1.rd_data;
    end
    checkOutput($sformatf("m%0d rd_valid", m), 64'(valid), 64'(q.size() != 0));
    checkOutput($sformatf("m%0d count", m), 64'(cnt), 64'(q.size()));
    checkOutput($sformatf("m%0d full", m), 64'(fl), 64'(q.size() == DEPTH));
    checkOutput($sformatf("m%0d overflow", m), 64'(ovf), 64'(mOvf[m]));
    if (q.size() != 0) begin
      checkOutput($sformatf("m%0d rd_data", m), 64'(data), 64'(q[0].data));
      checkOutput($sformatf("m%0d rd_pc", m), 64'(pc), 64'(q[0].pc));
      checkOutput($sformatf("m%0d rd_reg", m), 64'(rg), 64'(q[0].rg));
      checkOutput($sformatf("m%0d rd_stamp", m), 64'(st), 64'(q[0].stamp));
    end
  endtask

  // One clock: drive at the falling edge, advance the models, check just after the rising edge.
  task automatic applyStimulus(input logic r, e, v, input logic [31:0] pc,
                               input logic [4:0] rg, input logic [31:0] d, input logic rdy, clr);
    @(negedge clk);
    rst = r; en = e; ovfClr = clr;
    if0.wb_valid = v; if0.wb_pc = pc; if0.wb_reg = rg; if0.wb_data = d; if0.rd_ready = rdy;
    if1.wb_valid = v; if1.wb_pc = pc; if1.wb_reg = rg; if1.wb_data = d; if1.rd_ready = rdy;
    modelStep(0, r, e, v, pc, rg, d, rdy, clr);
    modelStep(1, r, e, v, pc, rg, d, rdy, clr);
    @(posedge clk);
    #1;
    checkDut(0);
    checkDut(1);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic commit(input logic [31:0] d, input logic rdy);
    applyStimulus(1'b0, 1'b1, 1'b1, d << 2, 5'd8 + 5'(d % 20), d, rdy, 1'b0);
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      idle(1'b1);
    end
    checkOutput("drain complete m0", 64'(count0), 64'd0);
    checkOutput("drain complete m1", 64'(count1), 64'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ovfClr = 1'b0;
    if0.wb_valid = 1'b0; if0.wb_pc = '0; if0.wb_reg = '0; if0.wb_data = '0; if0.rd_ready = 1'b0;
    if1.wb_valid = 1'b0; if1.wb_pc = '0; if1.wb_reg = '0; if1.wb_data = '0; if1.rd_ready = 1'b0;

    resetDut();
    checkOutput("reset count", 64'(count0), 64'd0);
    checkOutput("reset rd_valid", 64'(if0.rd_valid), 64'd0);

    // Single $s0 commit on the first edge after reset: stamp 0 expected.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h4, 5'd16, 32'h5, 1'b0, 1'b0);
    checkOutput("single rd_data", 64'(if0.rd_data), 64'h5);
    checkOutput("single rd_stamp", 64'(if0.rd_stamp), 64'h0);
    idle(1'b1);
    checkOutput("single popped", 64'(if0.rd_valid), 64'd0);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h8, 5'd0, 32'h77, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC, 5'd8, 32'h78, 1'b0, 1'b0);
    checkOutput("filtered count", 64'(count0), 64'd0);

    // 17 commits without reading: MODE0 keeps 1..16, MODE1 keeps 2..17.
    for (int i = 1; i <= 17; i++) commit(32'(i), 1'b0);
    checkOutput("m0 full count", 64'(count0), 64'd16);
    checkOutput("m0 full ovf", 64'(ovf0), 64'd1);
    checkOutput("m1 wrap head", 64'(if1.rd_data), 64'd2);
    drain();

    resetDut();
    for (int i = 1; i <= 20; i++) commit(32'(i), 1'b0);
    checkOutput("m1 wrap20 head", 64'(if1.rd_data), 64'd5);
    drain();

    // Full with simultaneous capture and pop, then an overflow edge with ovf_clr.
    resetDut();
    for (int i = 1; i <= 16; i++) commit(32'(i), 1'b0);
    for (int i = 17; i <= 20; i++) commit(32'(i), 1'b1);
    checkOutput("cap+pop ovf", 64'(ovf0), 64'd0);
    checkOutput("cap+pop head", 64'(if0.rd_data), 64'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 5'd9, 32'd21, 1'b0, 1'b1);
    checkOutput("set beats clr", 64'(ovf1), 64'd1);
    idle(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
    checkOutput("ovf cleared", 64'(ovf0), 64'd0);
    drain();

    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 9) < 7),
                    $urandom(),
                    5'($urandom_range(0, 7)),
                    $urandom(),
                    ($urandom_range(0, 9) < (i < 400 ? 3 : 7)),
                    ($urandom_range(0, 9) == 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
